// File: rtl/seg7_scan_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : seg7_pkg                                                        |
// | Purpose  : Shared constants for the 7-segment scan decoder: active-low     |
// |            segment patterns for 0..9 and blank, the blank/invalid digit    |
// |            codes, and the qualification FSM state type.                    |
// | Contents : SEG_0..SEG_9, SEG_BLANK, DIGIT_BLANK, DIGIT_INVALID,            |
// |            seg7_state_e {IDLE, QUAL, CAPT}                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package seg7_pkg;

   // Active-low segment patterns, bit0 = segment a ... bit6 = segment g
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] DIGIT_BLANK   = 4'hF;
   localparam logic [3:0] DIGIT_INVALID = 4'hE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      QUAL = 2'd1,
      CAPT = 2'd2
   } seg7_state_e;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: seg7_scan_decoder_if                                            |
// | Purpose  : Groups the observed display bus and the readback/status         |
// |            outputs of the scan decoder.                                    |
// | Signals  : seg, an, clr_err (display side -> decoder)                      |
// |            digits, dig_valid, upd, upd_idx, err_pattern, err_scan          |
// |            (decoder -> status logic)                                       |
// |            dp / dp_out only when SEG7_DP_CAPTURE_EN is defined             |
// | Modports : master (drives the display bus), slave (the decoder)            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface seg7_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   an;
   logic                    clr_err;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   dig_valid;
   logic                    upd;
   logic [2:0]              upd_idx;
   logic                    err_pattern;
   logic                    err_scan;
`ifdef SEG7_DP_CAPTURE_EN
   logic                    dp;
   logic [NUM_DIGITS-1:0]   dp_out;

   modport master (
      output seg, an, clr_err, dp,
      input  digits, dig_valid, upd, upd_idx, err_pattern, err_scan, dp_out
   );

   modport slave (
      input  seg, an, clr_err, dp,
      output digits, dig_valid, upd, upd_idx, err_pattern, err_scan, dp_out
   );
`else
   modport master (
      output seg, an, clr_err,
      input  digits, dig_valid, upd, upd_idx, err_pattern, err_scan
   );

   modport slave (
      input  seg, an, clr_err,
      output digits, dig_valid, upd, upd_idx, err_pattern, err_scan
   );
`endif
endinterface
`default_nettype wire

// File: rtl/seg7_scan_decoder_to_digit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_to_digit                                                   |
// | Purpose  : Combinational inverse of the BCD-to-7-segment encoder.          |
// | Ports    : seg_i   [6:0] active-low segment pattern (bit0 = a)             |
// |            digit_o [3:0] 0..9, DIGIT_BLANK for all-off, else DIGIT_INVALID |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seg7_to_digit
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] digit_o
);

   always_comb begin
      digit_o = DIGIT_INVALID;
      case (seg_i)
         SEG_0:     digit_o = 4'd0;
         SEG_1:     digit_o = 4'd1;
         SEG_2:     digit_o = 4'd2;
         SEG_3:     digit_o = 4'd3;
         SEG_4:     digit_o = 4'd4;
         SEG_5:     digit_o = 4'd5;
         SEG_6:     digit_o = 4'd6;
         SEG_7:     digit_o = 4'd7;
         SEG_8:     digit_o = 4'd8;
         SEG_9:     digit_o = 4'd9;
         SEG_BLANK: digit_o = DIGIT_BLANK;
         default:   digit_o = DIGIT_INVALID;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan_decoder                                               |
// | Purpose  : Readback monitor for a multiplexed active-low 7-segment bus.    |
// |            Each {an, seg} sample must be seen STABLE_CYCLES times in a row |
// |            on a single enabled digit before it is decoded and captured,    |
// |            which rejects scan transitions and ghosting.                    |
// | Ports    : clk, rst (sync, active-high)                                    |
// |            bus (slave): seg, an, clr_err in; digits, dig_valid, upd,       |
// |            upd_idx, err_pattern, err_scan out                              |
// | Options  : SEG7_DP_CAPTURE_EN adds dp input and dp_out output              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic               clk,
   input  logic               rst,
   seg7_scan_decoder_if.slave bus
);

`ifdef SEG7_DP_CAPTURE_EN
   localparam int c_SAMP_W = NUM_DIGITS + 8;
`else
   localparam int c_SAMP_W = NUM_DIGITS + 7;
`endif
   // The capture decision is made on the edge where the counter would reach
   // STABLE_CYCLES, so compare against one less.
   localparam logic [CNT_W-1:0]      c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]      c_CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]      c_CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [NUM_DIGITS-1:0] c_AN_ONE   = NUM_DIGITS'(1);

   // -------------------------------------------------------------------------
   // Input sampling: samp is the current sample, prev the one before it.
   // Reset to all-ones = every digit off, blank pattern, dp off.
   // -------------------------------------------------------------------------
   logic [c_SAMP_W-1:0] w_samp_in;
   logic [c_SAMP_W-1:0] samp_q;
   logic [c_SAMP_W-1:0] prev_q;

`ifdef SEG7_DP_CAPTURE_EN
   assign w_samp_in = {bus.dp, bus.an, bus.seg};
`else
   assign w_samp_in = {bus.an, bus.seg};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         samp_q <= {c_SAMP_W{1'b1}};
         prev_q <= {c_SAMP_W{1'b1}};
      end else begin
         samp_q <= w_samp_in;
         prev_q <= samp_q;
      end
   end

   // -------------------------------------------------------------------------
   // Sample classification
   // -------------------------------------------------------------------------
   logic [6:0]            w_seg;
   logic [NUM_DIGITS-1:0] w_an_act;
   logic                  w_one_hot;
   logic                  w_multi;
   logic                  w_stable;
   logic [2:0]            w_idx;
   logic [3:0]            w_dec;

   assign w_seg    = samp_q[6:0];
   assign w_an_act = ~samp_q[7 +: NUM_DIGITS];
   // x & (x-1) clears the lowest set bit; anything left means two or more.
   assign w_multi   = (w_an_act & (w_an_act - c_AN_ONE)) != '0;
   assign w_one_hot = (w_an_act != '0) && !w_multi;
   assign w_stable  = (samp_q == prev_q);

   always_comb begin
      w_idx = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_an_act[i]) begin
            w_idx = 3'(i);
         end
      end
   end

   seg7_to_digit u_dec (
      .seg_i   (w_seg),
      .digit_o (w_dec)
   );

   // -------------------------------------------------------------------------
   // Qualification FSM with registered outputs
   // -------------------------------------------------------------------------
   seg7_state_e             state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [4*NUM_DIGITS-1:0] digits_q;
   logic [NUM_DIGITS-1:0]   dig_valid_q;
   logic                    upd_q;
   logic [2:0]              upd_idx_q;
   logic                    err_pattern_q;
   logic                    err_scan_q;
`ifdef SEG7_DP_CAPTURE_EN
   logic [NUM_DIGITS-1:0]   dp_out_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         digits_q      <= {NUM_DIGITS{DIGIT_BLANK}};
         dig_valid_q   <= '0;
         upd_q         <= 1'b0;
         upd_idx_q     <= 3'd0;
         err_pattern_q <= 1'b0;
         err_scan_q    <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
         dp_out_q      <= '0;
`endif
      end else begin
         upd_q <= 1'b0;

         // Clear first; any set later in this block overrides it.
         if (bus.clr_err) begin
            err_pattern_q <= 1'b0;
            err_scan_q    <= 1'b0;
         end
         if (w_multi) begin
            err_scan_q <= 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (w_one_hot) begin
                  state_q <= QUAL;
                  cnt_q   <= c_CNT_ONE;
               end
            end

            QUAL: begin
               if (!w_one_hot) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (!w_stable) begin
                  cnt_q <= c_CNT_ONE;
               end else begin
                  if (cnt_q != c_CNT_MAX) begin
                     cnt_q <= cnt_q + c_CNT_ONE;
                  end
                  if (cnt_q >= c_CNT_LAST) begin
                     state_q   <= CAPT;
                     upd_q     <= 1'b1;
                     upd_idx_q <= w_idx;
                     if (w_dec == DIGIT_INVALID) begin
                        err_pattern_q <= 1'b1;
                     end
                     // Exactly one enable is active here, so one slot updates.
                     for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (w_an_act[i]) begin
                           digits_q[4*i +: 4] <= w_dec;
                           dig_valid_q[i]     <= 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
                           dp_out_q[i]        <= ~samp_q[c_SAMP_W-1];
`endif
                        end
                     end
                  end
               end
            end

            CAPT: begin
               // Hold off re-capture until the bus actually changes.
               if (!w_stable) begin
                  if (w_one_hot) begin
                     state_q <= QUAL;
                     cnt_q   <= c_CNT_ONE;
                  end else begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end
               end
            end

            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign bus.digits      = digits_q;
   assign bus.dig_valid   = dig_valid_q;
   assign bus.upd         = upd_q;
   assign bus.upd_idx     = upd_idx_q;
   assign bus.err_pattern = err_pattern_q;
   assign bus.err_scan    = err_scan_q;
`ifdef SEG7_DP_CAPTURE_EN
   assign bus.dp_out      = dp_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seg7_scan_decoder                                            |
// | Purpose  : Self-checking bench for seg7_scan_decoder: directed scenarios   |
// |            plus randomized scan traffic against a run-length reference.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_decoder;

   localparam int N = 4;
   localparam int S = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg7_scan_decoder_if #(.NUM_DIGITS(N)) bus ();

   seg7_scan_decoder #(
      .NUM_DIGITS    (N),
      .STABLE_CYCLES (S),
      .CNT_W         (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef SEG7_DP_CAPTURE_EN
   initial bus.dp = 1'b1;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model: a sample is captured when it is the S-th identical
   // sample in a row and exactly one enable is low.
   logic [6:0]     pat_tbl [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                     7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   logic [10:0]    last_s;
   logic [10:0]    m_run;
   int             m_len;
   logic [4*N-1:0] m_digits;
   logic [N-1:0]   m_valid;
   logic           m_upd;
   logic [2:0]     m_idx;
   logic           m_errp;
   logic           m_errs;

   function automatic logic [3:0] ref_decode(input logic [6:0] s);
      for (int i = 0; i < 10; i++) begin
         if (s == pat_tbl[i]) return 4'(i);
      end
      if (s == 7'h7F) return 4'hF;
      return 4'hE;
   endfunction

   task automatic model_reset();
      m_run    = '1;
      m_len    = 1;
      m_digits = '1;
      m_valid  = '0;
      m_upd    = 1'b0;
      m_idx    = 3'd0;
      m_errp   = 1'b0;
      m_errs   = 1'b0;
   endtask

   task automatic model_edge(input logic [10:0] v, input logic clr);
      logic [3:0] an;
      logic [3:0] val;
      int         nlow;
      int         pos;
      an = v[10:7];
      if (v == m_run) begin
         if (m_len < 1000) m_len++;
      end else begin
         m_run = v;
         m_len = 1;
      end
      m_upd = 1'b0;
      if (clr) begin
         m_errp = 1'b0;
         m_errs = 1'b0;
      end
      nlow = $countones(~an);
      if (nlow > 1) m_errs = 1'b1;
      if (nlow == 1 && m_len == S) begin
         pos = 0;
         for (int i = 0; i < N; i++) if (!an[i]) pos = i;
         val = ref_decode(v[6:0]);
         m_digits[4*pos +: 4] = val;
         m_valid[pos] = 1'b1;
         m_upd = 1'b1;
         m_idx = 3'(pos);
         if (val == 4'hE) m_errp = 1'b1;
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s);
      bus.an  = a;
      bus.seg = s;
   endtask

   // One clock: update the model for this edge, then sample outputs #1 after.
   task automatic step(input logic r);
      logic [10:0] cur;
      rst = r;
      cur = {bus.an, bus.seg};
      if (r) model_reset();
      else   model_edge(last_s, bus.clr_err);
      last_s = r ? '1 : cur;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(4'hF, 7'h7F);
      bus.clr_err = 1'b0;
      step(1'b1);
      step(1'b1);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.digits !== 16'hFFFF) begin failures++; $display("FAIL reset_digits got=%h want=%h", bus.digits, 16'hFFFF); end
      checks++; if (bus.dig_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%h want=0", bus.dig_valid); end
      checks++; if (bus.upd !== 1'b0 || bus.upd_idx !== 3'd0) begin failures++; $display("FAIL reset_upd got upd=%b idx=%0d want 0/0", bus.upd, bus.upd_idx); end
      checks++; if (bus.err_pattern !== 1'b0 || bus.err_scan !== 1'b0) begin failures++; $display("FAIL reset_err got p=%b s=%b want 0/0", bus.err_pattern, bus.err_scan); end
   endtask

   task automatic test_single();
      int nupd = 0;
      int first = -1;
      logic [2:0] idx = 3'd7;
      do_reset();
      drive(4'b1110, 7'h24);
      for (int i = 0; i < 10; i++) begin
         step(1'b0);
         if (bus.upd === 1'b1) begin
            nupd++;
            if (first < 0) begin first = i; idx = bus.upd_idx; end
         end
      end
      checks++; if (nupd != 1) begin failures++; $display("FAIL single_count got=%0d want=1", nupd); end
      checks++; if (first != S) begin failures++; $display("FAIL single_latency got=%0d want=%0d", first, S); end
      checks++; if (idx !== 3'd0) begin failures++; $display("FAIL single_idx got=%0d want=0", idx); end
      checks++; if (bus.digits[3:0] !== 4'd2) begin failures++; $display("FAIL single_digit got=%h want=2", bus.digits[3:0]); end
      checks++; if (bus.dig_valid !== 4'b0001) begin failures++; $display("FAIL single_valid got=%b want=0001", bus.dig_valid); end
   endtask

   task automatic test_scan();
      int nupd = 0;
      logic [3:0] a;
      do_reset();
      for (int d = 0; d < 4; d++) begin
         a = 4'b0001 << d;
         drive(~a, pat_tbl[d+1]);
         for (int i = 0; i < 6; i++) begin
            step(1'b0);
            if (bus.upd === 1'b1) nupd++;
         end
         drive(4'hF, 7'h7F);
         step(1'b0);
         if (bus.upd === 1'b1) nupd++;
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0);
         if (bus.upd === 1'b1) nupd++;
      end
      checks++; if (bus.digits !== 16'h4321) begin failures++; $display("FAIL scan_digits got=%h want=4321", bus.digits); end
      checks++; if (bus.dig_valid !== 4'hF) begin failures++; $display("FAIL scan_valid got=%h want=f", bus.dig_valid); end
      checks++; if (nupd != 4) begin failures++; $display("FAIL scan_upd_count got=%0d want=4", nupd); end
      checks++; if (bus.err_pattern !== 1'b0 || bus.err_scan !== 1'b0) begin failures++; $display("FAIL scan_err got p=%b s=%b want 0/0", bus.err_pattern, bus.err_scan); end
   endtask

   task automatic test_short();
      int nupd = 0;
      do_reset();
      drive(4'b1110, 7'h24);
      for (int i = 0; i < S - 1; i++) begin
         step(1'b0);
         if (bus.upd === 1'b1) nupd++;
      end
      drive(4'hF, 7'h7F);
      for (int i = 0; i < 6; i++) begin
         step(1'b0);
         if (bus.upd === 1'b1) nupd++;
      end
      checks++; if (nupd != 0) begin failures++; $display("FAIL short_upd got=%0d want=0", nupd); end
      checks++; if (bus.digits !== 16'hFFFF) begin failures++; $display("FAIL short_digits got=%h want=ffff", bus.digits); end
   endtask

   task automatic test_bad_pattern();
      do_reset();
      drive(4'b1101, 7'h55);
      for (int i = 0; i < 6; i++) step(1'b0);
      checks++; if (bus.digits[7:4] !== 4'hE) begin failures++; $display("FAIL badpat_digit got=%h want=e", bus.digits[7:4]); end
      checks++; if (bus.err_pattern !== 1'b1) begin failures++; $display("FAIL badpat_err got=%b want=1", bus.err_pattern); end
      drive(4'hF, 7'h7F);
      bus.clr_err = 1'b1;
      step(1'b0);
      bus.clr_err = 1'b0;
      checks++; if (bus.err_pattern !== 1'b0) begin failures++; $display("FAIL badpat_clr got=%b want=0", bus.err_pattern); end
   endtask

   task automatic test_scan_err();
      int nupd = 0;
      do_reset();
      drive(4'b1100, 7'h24);
      step(1'b0);
      drive(4'hF, 7'h7F);
      for (int i = 0; i < 5; i++) begin
         step(1'b0);
         if (bus.upd === 1'b1) nupd++;
      end
      checks++; if (bus.err_scan !== 1'b1) begin failures++; $display("FAIL scanerr_set got=%b want=1", bus.err_scan); end
      checks++; if (nupd != 0 || bus.dig_valid !== 4'h0) begin failures++; $display("FAIL scanerr_nocap got upd=%0d valid=%h want 0/0", nupd, bus.dig_valid); end
      bus.clr_err = 1'b1;
      step(1'b0);
      bus.clr_err = 1'b0;
      checks++; if (bus.err_scan !== 1'b0) begin failures++; $display("FAIL scanerr_clr got=%b want=0", bus.err_scan); end
      // Clear arrives on the same edge that sees the next multi-enable sample.
      drive(4'b1100, 7'h24);
      step(1'b0);
      drive(4'hF, 7'h7F);
      bus.clr_err = 1'b1;
      step(1'b0);
      bus.clr_err = 1'b0;
      checks++; if (bus.err_scan !== 1'b1) begin failures++; $display("FAIL scanerr_setwins got=%b want=1", bus.err_scan); end
   endtask

   task automatic test_reset_mid();
      int nupd = 0;
      do_reset();
      drive(4'b0111, 7'h79);
      for (int i = 0; i < 6; i++) step(1'b0);
      drive(4'b1100, 7'h7F);
      step(1'b0);
      drive(4'hF, 7'h7F);
      step(1'b0);
      step(1'b0);
      checks++; if (bus.upd_idx !== 3'd3 || bus.err_scan !== 1'b1) begin failures++; $display("FAIL rstmid_pre got idx=%0d errs=%b want 3/1", bus.upd_idx, bus.err_scan); end
      drive(4'b1011, 7'h30);
      for (int i = 0; i < S; i++) begin
         step(1'b0);
         if (bus.upd === 1'b1) nupd++;
      end
      step(1'b1);
      if (bus.upd === 1'b1) nupd++;
      checks++; if (nupd != 0) begin failures++; $display("FAIL rstmid_upd got=%0d want=0", nupd); end
      checks++; if (bus.digits !== 16'hFFFF || bus.dig_valid !== 4'h0) begin failures++; $display("FAIL rstmid_data got digits=%h valid=%h want ffff/0", bus.digits, bus.dig_valid); end
      checks++; if (bus.upd_idx !== 3'd0 || bus.err_scan !== 1'b0 || bus.err_pattern !== 1'b0) begin failures++; $display("FAIL rstmid_status got idx=%0d s=%b p=%b want 0/0/0", bus.upd_idx, bus.err_scan, bus.err_pattern); end
      drive(4'hF, 7'h7F);
      step(1'b0);
   endtask

   task automatic test_random();
      logic [3:0] multi_tbl [0:3] = '{4'b1100, 4'b0101, 4'b0000, 4'b1001};
      logic [3:0] a;
      logic [6:0] s;
      int kind;
      int hold;
      do_reset();
      for (int seg_n = 0; seg_n < 45; seg_n++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0)      a = multi_tbl[$urandom_range(0, 3)];
         else if (kind <= 2) a = 4'hF;
         else                a = ~(4'b0001 << $urandom_range(0, 3));
         if ($urandom_range(0, 9) < 7) s = pat_tbl[$urandom_range(0, 9)];
         else if ($urandom_range(0, 1) == 0) s = 7'h7F;
         else s = 7'($urandom);
         hold = $urandom_range(1, 7);
         drive(a, s);
         for (int i = 0; i < hold; i++) begin
            bus.clr_err = ($urandom_range(0, 7) == 0);
            step(1'b0);
            checks++; if (bus.digits !== m_digits) begin failures++; $display("FAIL rand_digits got=%h want=%h", bus.digits, m_digits); end
            checks++; if (bus.dig_valid !== m_valid) begin failures++; $display("FAIL rand_valid got=%h want=%h", bus.dig_valid, m_valid); end
            checks++; if (bus.upd !== m_upd) begin failures++; $display("FAIL rand_upd got=%b want=%b", bus.upd, m_upd); end
            if (m_upd) begin
               checks++; if (bus.upd_idx !== m_idx) begin failures++; $display("FAIL rand_idx got=%0d want=%0d", bus.upd_idx, m_idx); end
            end
            checks++; if (bus.err_pattern !== m_errp || bus.err_scan !== m_errs) begin failures++; $display("FAIL rand_err got p=%b s=%b want p=%b s=%b", bus.err_pattern, bus.err_scan, m_errp, m_errs); end
         end
      end
      bus.clr_err = 1'b0;
   endtask

   initial begin
      last_s = '1;
      model_reset();
      test_reset();
      test_single();
      test_scan();
      test_short();
      test_bad_pattern();
      test_scan_err();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
